// File: rtl/flash_bus_arbiter.sv
// flash_bus_arbiter
//
// Shares one parallel flash device between two requesters (AVR and Coco).
// Each requester raises a single-cycle req pulse; the arbiter remembers it in
// a pending flag, grants the bus, and runs a fixed access sequence:
//   IDLE -> SETUP (1 tick) -> STROBE (max(cfg_wait,1) ticks) -> HOLD (1 tick)
// AVR has fixed priority. A starvation counter lets Coco win once AVR has
// been granted STARVE_LIMIT times in a row while Coco was waiting.
//
// Ports
//   clock_50, reset_n                     clock, asynchronous active-low reset
//   cfg_wait[2:0]                         strobe width in clock ticks (0 acts as 1)
//   avr_req/rw/addr/wdata, avr_ack/rdata  AVR request side
//   coco_req/rw/addr/wdata, coco_ack/rdata Coco request side
//   fl_addr, fl_dout, fl_dout_en, fl_din  flash address and data buses
//   fl_ce_n, fl_oe_n, fl_we_n             flash control strobes (active low)
//   busy                                  high whenever the FSM is not IDLE
//
// Every output comes straight from a flop; the flop inputs are derived from
// the next state so the pins change on the same edge as the state.

module flash_bus_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic [2:0]  cfg_wait,
    input  logic        avr_req,
    input  logic        avr_rw,
    input  logic [15:0] avr_addr,
    input  logic [7:0]  avr_wdata,
    output logic        avr_ack,
    output logic [7:0]  avr_rdata,
    input  logic        coco_req,
    input  logic        coco_rw,
    input  logic [15:0] coco_addr,
    input  logic [7:0]  coco_wdata,
    output logic        coco_ack,
    output logic [7:0]  coco_rdata,
    output logic [15:0] fl_addr,
    output logic [7:0]  fl_dout,
    output logic        fl_dout_en,
    input  logic [7:0]  fl_din,
    output logic        fl_ce_n,
    output logic        fl_oe_n,
    output logic        fl_we_n,
    output logic        busy
);

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          avr_pend_reg, avr_pend_next;
    logic          coco_pend_reg, coco_pend_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic          owner_coco_reg, owner_coco_next;   // 1 = Coco owns the cycle
    logic          rw_reg, rw_next;
    logic [15:0]   addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic [2:0]    cnt_reg, cnt_next;                 // STROBE ticks remaining - 1
    logic [7:0]    avr_rdata_reg, avr_rdata_next;
    logic [7:0]    coco_rdata_reg, coco_rdata_next;
    logic          avr_ack_reg, avr_ack_next;
    logic          coco_ack_reg, coco_ack_next;
    logic          ce_n_reg, ce_n_next;
    logic          oe_n_reg, oe_n_next;
    logic          we_n_reg, we_n_next;
    logic          dout_en_reg, dout_en_next;
    logic          busy_reg, busy_next;
    logic          pick_coco;

    always_comb begin
        state_next      = state_reg;
        // A pulse while the flag is already set simply ORs into a 1.
        avr_pend_next   = avr_pend_reg | avr_req;
        coco_pend_next  = coco_pend_reg | coco_req;
        starve_next     = starve_reg;
        owner_coco_next = owner_coco_reg;
        rw_next         = rw_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        avr_rdata_next  = avr_rdata_reg;
        coco_rdata_next = coco_rdata_reg;
        avr_ack_next    = 1'b0;
        coco_ack_next   = 1'b0;

        // Arbitration uses the counter value from before this grant.
        pick_coco = coco_pend_reg && (!avr_pend_reg || (starve_reg == STARVE_MAX));

        case (state_reg)
            IDLE: begin
                if (avr_pend_reg || coco_pend_reg) begin
                    state_next      = SETUP;
                    owner_coco_next = pick_coco;
                    if (pick_coco) begin
                        starve_next = '0;
                    end else if (coco_pend_reg && (starve_reg != STARVE_MAX)) begin
                        starve_next = starve_reg + 1'b1;
                    end
                    // Snapshot the winner's request so later input changes
                    // cannot disturb the cycle in flight.
                    rw_next    = pick_coco ? coco_rw    : avr_rw;
                    addr_next  = pick_coco ? coco_addr  : avr_addr;
                    wdata_next = pick_coco ? coco_wdata : avr_wdata;
                    cnt_next   = (cfg_wait == 3'd0) ? 3'd0 : (cfg_wait - 3'd1);
                end
            end
            SETUP: begin
                state_next = STROBE;
            end
            STROBE: begin
                if (cnt_reg == 3'd0) begin
                    state_next = HOLD;
                    // Last strobe tick: data from the flash is valid now.
                    if (rw_reg) begin
                        if (owner_coco_reg) coco_rdata_next = fl_din;
                        else                avr_rdata_next  = fl_din;
                    end
                    if (owner_coco_reg) coco_ack_next = 1'b1;
                    else                avr_ack_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            HOLD: begin
                state_next = IDLE;
                // A fresh pulse coinciding with the ack starts a new request.
                if (owner_coco_reg) coco_pend_next = coco_req;
                else                avr_pend_next  = avr_req;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ce_n_next    = (state_next == IDLE);
        oe_n_next    = !((state_next == STROBE) && rw_next);
        we_n_next    = !((state_next == STROBE) && !rw_next);
        dout_en_next = (state_next != IDLE) && !rw_next;
        busy_next    = (state_next != IDLE);
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            avr_pend_reg   <= 1'b0;
            coco_pend_reg  <= 1'b0;
            starve_reg     <= '0;
            owner_coco_reg <= 1'b0;
            rw_reg         <= 1'b1;
            addr_reg       <= 16'h0000;
            wdata_reg      <= 8'h00;
            cnt_reg        <= 3'd0;
            avr_rdata_reg  <= 8'h00;
            coco_rdata_reg <= 8'h00;
            avr_ack_reg    <= 1'b0;
            coco_ack_reg   <= 1'b0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            dout_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            avr_pend_reg   <= avr_pend_next;
            coco_pend_reg  <= coco_pend_next;
            starve_reg     <= starve_next;
            owner_coco_reg <= owner_coco_next;
            rw_reg         <= rw_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
            avr_rdata_reg  <= avr_rdata_next;
            coco_rdata_reg <= coco_rdata_next;
            avr_ack_reg    <= avr_ack_next;
            coco_ack_reg   <= coco_ack_next;
            ce_n_reg       <= ce_n_next;
            oe_n_reg       <= oe_n_next;
            we_n_reg       <= we_n_next;
            dout_en_reg    <= dout_en_next;
            busy_reg       <= busy_next;
        end
    end

    assign avr_ack    = avr_ack_reg;
    assign avr_rdata  = avr_rdata_reg;
    assign coco_ack   = coco_ack_reg;
    assign coco_rdata = coco_rdata_reg;
    assign fl_addr    = addr_reg;
    assign fl_dout    = wdata_reg;
    assign fl_dout_en = dout_en_reg;
    assign fl_ce_n    = ce_n_reg;
    assign fl_oe_n    = oe_n_reg;
    assign fl_we_n    = we_n_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Testbench for flash_bus_arbiter.
// A small flash device model answers the bus (256 bytes, decoded from the low
// address byte, read data valid only on the final strobe tick). A separate
// reference memory, updated per completed transaction, gives expected read data.

module tb_flash_bus_arbiter;

    logic        clock_50;
    logic        reset_n;
    logic [2:0]  cfg_wait;
    logic        avr_req, avr_rw, avr_ack;
    logic [15:0] avr_addr;
    logic [7:0]  avr_wdata, avr_rdata;
    logic        coco_req, coco_rw, coco_ack;
    logic [15:0] coco_addr;
    logic [7:0]  coco_wdata, coco_rdata;
    logic [15:0] fl_addr;
    logic [7:0]  fl_dout, fl_din;
    logic        fl_dout_en, fl_ce_n, fl_oe_n, fl_we_n, busy;

    int vectors = 0;
    int miscompares = 0;
    int cur_len = 1;
    int oe_cnt = 0;
    bit mon_en = 1'b0;

    bit [7:0] dev_mem [256];
    bit       dev_wr  [256];
    bit [7:0] model_mem [256];
    bit       model_wr  [256];
    logic [7:0] dev_rd;

    flash_bus_arbiter #(.STARVE_LIMIT(3)) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .cfg_wait   (cfg_wait),
        .avr_req    (avr_req),
        .avr_rw     (avr_rw),
        .avr_addr   (avr_addr),
        .avr_wdata  (avr_wdata),
        .avr_ack    (avr_ack),
        .avr_rdata  (avr_rdata),
        .coco_req   (coco_req),
        .coco_rw    (coco_rw),
        .coco_addr  (coco_addr),
        .coco_wdata (coco_wdata),
        .coco_ack   (coco_ack),
        .coco_rdata (coco_rdata),
        .fl_addr    (fl_addr),
        .fl_dout    (fl_dout),
        .fl_dout_en (fl_dout_en),
        .fl_din     (fl_din),
        .fl_ce_n    (fl_ce_n),
        .fl_oe_n    (fl_oe_n),
        .fl_we_n    (fl_we_n),
        .busy       (busy)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    // Power-up contents of a never-written byte.
    function automatic logic [7:0] pat(input logic [7:0] a);
        return 8'((a * 8'd37) + 8'd11);
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return model_wr[a] ? model_mem[a] : pat(a);
    endfunction

    // ---------------- flash device model ----------------
    always @(posedge clock_50) begin
        oe_cnt <= fl_oe_n ? 0 : oe_cnt + 1;
        if (reset_n && !fl_ce_n && !fl_we_n) begin
            dev_mem[fl_addr[7:0]] <= fl_dout;
            dev_wr[fl_addr[7:0]]  <= 1'b1;
        end
    end
    assign dev_rd = dev_wr[fl_addr[7:0]] ? dev_mem[fl_addr[7:0]] : pat(fl_addr[7:0]);
    assign fl_din = (!fl_oe_n && (oe_cnt == cur_len - 1)) ? dev_rd : ~dev_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus protocol monitor ----------------
    always @(negedge clock_50) begin
        if (reset_n && mon_en) begin
            chk("oe_we_exclusive", 32'(fl_oe_n | fl_we_n), 32'd1);
            if (!fl_we_n) chk("we_needs_dout_en", 32'(fl_dout_en), 32'd1);
            if (!fl_oe_n) chk("oe_needs_no_dout_en", 32'(fl_dout_en), 32'd0);
            chk("busy_vs_ce", 32'(busy), 32'(!fl_ce_n));
        end
    end

    // One uncontended transaction, checked end to end. Inputs are scrambled
    // once SETUP is visible to prove the request was latched.
    task automatic run_one(input bit who, input bit rw, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [2:0] w);
        int len, n, lat, strb, en_cnt, other_ack;
        bit got, setup_seen;
        logic [7:0] other_rd;
        len = (w == 3'd0) ? 1 : int'(w);
        cur_len = len;
        other_rd = who ? avr_rdata : coco_rdata;
        cfg_wait = w;
        if (who) begin
            coco_rw = rw; coco_addr = addr; coco_wdata = wd; coco_req = 1'b1;
        end else begin
            avr_rw = rw; avr_addr = addr; avr_wdata = wd; avr_req = 1'b1;
        end
        @(negedge clock_50);
        avr_req = 1'b0; coco_req = 1'b0;
        n = 1; lat = 0; strb = 0; en_cnt = 0; other_ack = 0; got = 0; setup_seen = 0;
        while (!got && n <= 40) begin
            if (!fl_ce_n && !setup_seen) begin
                setup_seen = 1;
                cfg_wait = 3'($urandom);
                if (who) begin
                    coco_rw = ~rw; coco_addr = 16'($urandom); coco_wdata = 8'($urandom);
                end else begin
                    avr_rw = ~rw; avr_addr = 16'($urandom); avr_wdata = 8'($urandom);
                end
            end
            if (rw ? !fl_oe_n : !fl_we_n) begin
                strb++;
                chk("strobe_addr", 32'(fl_addr), 32'(addr));
                if (!rw) chk("strobe_dout", 32'(fl_dout), 32'(wd));
            end
            if (fl_dout_en) en_cnt++;
            if (who ? avr_ack : coco_ack) other_ack++;
            if (who ? coco_ack : avr_ack) begin
                got = 1;
                lat = n;
                chk("hold_ce_n", 32'(fl_ce_n), 32'd0);
                chk("hold_oe_we", 32'({fl_oe_n, fl_we_n}), 32'd3);
                chk("hold_addr", 32'(fl_addr), 32'(addr));
            end else begin
                @(negedge clock_50);
                n++;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(3 + len));
        chk("strobe_len", 32'(strb), 32'(len));
        chk("dout_en_len", 32'(en_cnt), rw ? 32'd0 : 32'(len + 2));
        chk("other_ack", 32'(other_ack), 32'd0);
        if (rw) chk("rdata", 32'(who ? coco_rdata : avr_rdata), 32'(model_rd(addr[7:0])));
        else begin
            model_mem[addr[7:0]] = wd;
            model_wr[addr[7:0]]  = 1'b1;
        end
        chk("other_rdata_kept", 32'(who ? avr_rdata : coco_rdata), 32'(other_rd));
        @(negedge clock_50);
        chk("ack_one_tick", 32'({avr_ack, coco_ack}), 32'd0);
        chk("back_to_idle", 32'(busy), 32'd0);
        $display("txn %s %s addr=%04h w=%0d lat=%0d", who ? "coco" : "avr ",
                 rw ? "rd" : "wr", addr, w, lat);
    endtask

    initial begin
        int t_a, t_c, gap, k, rep, acks, busy_seen;
        int seq [8];
        int exp_seq [6];
        exp_seq = '{0, 0, 0, 1, 0, 0};

        reset_n = 1'b0; cfg_wait = 3'd0;
        avr_req = 0; avr_rw = 1; avr_addr = 0; avr_wdata = 0;
        coco_req = 0; coco_rw = 1; coco_addr = 0; coco_wdata = 0;
        repeat (3) @(negedge clock_50);

        // Reset state
        chk("rst_ctrl", 32'({fl_ce_n, fl_oe_n, fl_we_n, fl_dout_en}), 32'hE);
        chk("rst_busy_ack", 32'({busy, avr_ack, coco_ack}), 32'd0);
        chk("rst_rdata", 32'({avr_rdata, coco_rdata}), 32'd0);
        chk("rst_addr", 32'(fl_addr), 32'd0);
        // A request during reset is dropped.
        avr_req = 1'b1;
        @(negedge clock_50);
        avr_req = 1'b0;
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clock_50);
            chk("rst_req_dropped", 32'(busy), 32'd0);
        end

        // Write 8'hA5, then AVR read with cfg_wait=4 (7 ticks total).
        run_one(1'b1, 1'b0, 16'h0042, 8'hA5, 3'd2);
        run_one(1'b0, 1'b1, 16'h0042, 8'h00, 3'd4);
        chk("avr_read_a5", 32'(avr_rdata), 32'hA5);
        // Coco write 16'h1234 / 8'h3C with cfg_wait=0.
        run_one(1'b1, 1'b0, 16'h1234, 8'h3C, 3'd0);

        // Simultaneous requests, starve count zero: AVR then Coco.
        cfg_wait = 3'd2; cur_len = 2;
        avr_rw = 1; avr_addr = 16'h0003;
        coco_rw = 0; coco_addr = 16'h0005; coco_wdata = 8'h77;
        avr_req = 1; coco_req = 1;
        @(negedge clock_50);
        avr_req = 0; coco_req = 0;
        t_a = 0; t_c = 0; gap = 0;
        for (int n = 1; n <= 40; n++) begin
            if (avr_ack && t_a == 0) t_a = n;
            if (coco_ack && t_c == 0) t_c = n;
            if (t_a != 0 && t_c == 0 && !busy) gap++;
            @(negedge clock_50);
        end
        chk("simul_avr_first", 32'(t_a), 32'd5);
        chk("simul_coco_next", 32'(t_c), 32'd10);
        chk("simul_idle_gap", 32'(gap), 32'd1);
        chk("simul_avr_rdata", 32'(avr_rdata), 32'(model_rd(8'h03)));
        model_mem[8'h05] = 8'h77; model_wr[8'h05] = 1'b1;
        $display("txn simul avr@%0d coco@%0d gap=%0d", t_a, t_c, gap);

        // Continuous AVR with Coco pending: A A A C A A.
        cfg_wait = 3'd1; cur_len = 1;
        avr_rw = 0; avr_addr = 16'h0010; avr_wdata = 8'h99;
        coco_rw = 0; coco_addr = 16'h0011; coco_wdata = 8'h66;
        avr_req = 1; coco_req = 1;
        @(negedge clock_50);
        avr_req = 0; coco_req = 0;
        k = 0; rep = 4;
        for (int n = 1; n <= 80; n++) begin
            avr_req = 1'b0;
            if (avr_ack) begin
                if (k < 8) seq[k] = 0;
                k++;
                if (rep > 0) begin avr_req = 1'b1; rep--; end
            end
            if (coco_ack) begin
                if (k < 8) seq[k] = 1;
                k++;
            end
            @(negedge clock_50);
        end
        avr_req = 1'b0;
        chk("starve_grant_count", 32'(k), 32'd6);
        for (int i = 0; i < 6; i++) chk("starve_order", 32'(seq[i]), 32'(exp_seq[i]));
        model_mem[8'h10] = 8'h99; model_wr[8'h10] = 1'b1;
        model_mem[8'h11] = 8'h66; model_wr[8'h11] = 1'b1;
        $display("txn starve grants=%0d", k);

        // Re-pulse while pending gives exactly one cycle.
        cfg_wait = 3'd3; cur_len = 3;
        avr_rw = 1; avr_addr = 16'h0006;
        avr_req = 1;
        @(negedge clock_50);
        avr_req = 0;
        acks = 0;
        for (int n = 1; n <= 30; n++) begin
            avr_req = (n == 2);
            if (avr_ack) acks++;
            @(negedge clock_50);
        end
        avr_req = 0;
        chk("repulse_one_cycle", 32'(acks), 32'd1);
        chk("repulse_rdata", 32'(avr_rdata), 32'(model_rd(8'h06)));
        $display("txn repulse acks=%0d", acks);

        // Randomized uncontended traffic.
        for (int i = 0; i < 40; i++) begin
            run_one(1'($urandom), 1'($urandom), {8'($urandom), 5'd0, 3'($urandom)},
                    8'($urandom), 3'($urandom));
        end

        // Reset during the strobe of a write.
        cfg_wait = 3'd3; cur_len = 3;
        coco_rw = 0; coco_addr = 16'h00FF; coco_wdata = 8'h12;
        coco_req = 1;
        @(negedge clock_50);
        coco_req = 0;
        for (int i = 0; i < 10 && fl_we_n; i++) @(negedge clock_50);
        chk("rst_we_reached", 32'(fl_we_n), 32'd0);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(fl_we_n), 32'd1);
        chk("rst_mid_ctrl", 32'({fl_ce_n, fl_oe_n, fl_dout_en, busy}), 32'hC);
        chk("rst_mid_rdata", 32'({avr_rdata, coco_rdata}), 32'd0);
        chk("rst_mid_addr", 32'(fl_addr), 32'd0);
        @(negedge clock_50);
        @(negedge clock_50);
        reset_n = 1'b1;
        acks = 0; busy_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock_50);
            if (avr_ack || coco_ack) acks++;
            if (busy) busy_seen++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        chk("rst_pend_cleared", 32'(busy_seen), 32'd0);
        $display("txn reset-abort acks=%0d busy=%0d", acks, busy_seen);

        for (int i = 0; i < 4; i++) begin
            run_one(1'($urandom), 1'($urandom), {8'($urandom), 5'd0, 3'($urandom)},
                    8'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flash_bus_arbiter.md
FLASH_BUS_ARBITER -- requirements
Module: flash_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: the maximum number of consecutive AVR grants while a Coco request is pending.
REQ-002 SHALL have ports as follows:
- clock_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_wait  in  3  strobe width in clock_50 ticks
- avr_req  in  1  single-cycle request pulse
- avr_rw  in  1  1=read, 0=write
- avr_addr  in  16  AVR address
- avr_wdata  in  8  AVR write data
- avr_ack  out  1  completion pulse
- avr_rdata  out  8  AVR read data
- coco_req  in  1  single-cycle request pulse
- coco_rw  in  1  1=read, 0=write
- coco_addr  in  16  Coco address
- coco_wdata  in  8  Coco write data
- coco_ack  out  1  completion pulse
- coco_rdata  out  8  Coco read data
- fl_addr  out  16  flash address
- fl_dout  out  8  flash write data
- fl_dout_en  out  1  enable for the data-bus driver
- fl_din  in  8  flash read data
- fl_ce_n  out  1  flash chip enable
- fl_oe_n  out  1  flash output enable
- fl_we_n  out  1  flash write enable
- busy  out  1  high in every state except IDLE

Function
REQ-003 SHALL set a pending flag (avr_pend/coco_pend) on each req pulse; a pulse that arrives while that flag is already set is ignored.
REQ-004 SHALL treat a req pulse in the same cycle as that requester's ack as a new request, leaving the flag set.
REQ-005 SHALL implement states IDLE, SETUP, STROBE and HOLD, moving IDLE->SETUP->STROBE->HOLD->IDLE.
REQ-006 In IDLE with any pend flag set, SHALL grant one requester and enter SETUP on the next clock.
REQ-007 Arbitration SHALL be fixed AVR priority, except Coco wins when coco_pend=1 and starve_cnt==STARVE_LIMIT.
REQ-008 starve_cnt SHALL increment on each AVR grant made while coco_pend=1, saturate at STARVE_LIMIT, and clear on each Coco grant.
REQ-009 On entry to SETUP, SHALL latch the granted requester's rw, addr and wdata, plus cfg_wait; later input changes SHALL NOT affect the cycle in progress.
REQ-010 SETUP SHALL last 1 tick: fl_addr driven, fl_ce_n=0, fl_oe_n=1, fl_we_n=1; for writes, fl_dout_en=1.
REQ-011 STROBE SHALL last max(latched cfg_wait,1) ticks, with fl_oe_n=0 for reads or fl_we_n=0 for writes.
REQ-012 For reads, SHALL capture fl_din on the last STROBE tick into the granted requester's rdata register; the other requester's rdata SHALL remain unchanged.
REQ-013 HOLD SHALL last 1 tick: fl_oe_n=1, fl_we_n=1, fl_ce_n=0, address held, and fl_dout_en held for writes.
REQ-014 In HOLD, SHALL pulse the granted requester's ack for exactly 1 tick and clear its pend flag, subject to REQ-004.
REQ-015 SHALL make total latency from pend set to ack 3+max(cfg_wait,1) ticks with no contention.
REQ-016 In IDLE, SHALL drive fl_ce_n=1, fl_oe_n=1, fl_we_n=1 and fl_dout_en=0; fl_addr holds its last value.
REQ-017 fl_oe_n and fl_we_n SHALL never both be 0, and SHALL NOT assert while fl_dout_en conflicts with the direction.
REQ-018 When both requests arrive in the same cycle, SHALL apply REQ-007 using the starve_cnt value before the grant.
REQ-019 SHALL make all outputs registered; no output SHALL glitch combinationally from the req inputs.

Reset
REQ-020 While reset_n=0, SHALL immediately force state=IDLE, fl_ce_n/oe_n/we_n=1, fl_dout_en=0, both pend flags=0, starve_cnt=0, acks=0, busy=0, rdata=8'h00 and fl_addr=16'h0000.
REQ-021 Reset asserted mid-cycle SHALL abort the cycle with no ack; a request in progress is lost and must be reissued by the requester.
REQ-022 SHALL leave IDLE no earlier than the first clock after reset_n deasserts.

Verification
REQ-023 AVR read, cfg_wait=4, fl_din=8'hA5 -> SETUP 1 tick, fl_oe_n low 4 ticks, avr_ack in HOLD, avr_rdata=8'hA5, 7 ticks total.
REQ-024 Coco write addr 16'h1234, data 8'h3C, cfg_wait=0 -> fl_we_n low exactly 1 tick with fl_addr=16'h1234 and fl_dout=8'h3C; fl_dout_en spans SETUP through HOLD.
REQ-025 Simultaneous avr_req and coco_req with starve_cnt=0 -> AVR served first, Coco immediately after, with no IDLE gap beyond 1 tick.
REQ-026 Continuous AVR requests with Coco pending, STARVE_LIMIT=3 -> 3 AVR cycles, then the Coco cycle, then AVR resumes.
REQ-027 reset_n pulsed low during STROBE of a write -> fl_we_n=1 in the same cycle, no ack, pend flags cleared.
REQ-028 avr_req re-pulsed while avr_pend=1 -> exactly one AVR cycle performed.
